// File: rtl/interrupt_controller.sv
// interrupt_controller: latches peripheral interrupt edges as pending, masks them and raises a
// fixed-priority request/cause pair for Coprocessor 0. Optional macro INTC_IRQ_SYNC_EN adds input synchronizers.
module interrupt_controller #(
   parameter int unsigned NUM_SRC = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_SRC-1:0] IrqIn,
   input  logic               MaskWrite,
   input  logic [NUM_SRC-1:0] MaskWdata,
   input  logic               ClrWrite,
   input  logic [NUM_SRC-1:0] ClrWdata,
   input  logic               InteAccept,
   output logic               Interrupt,
   output logic [31:0]        InteCause,
   output logic [NUM_SRC-1:0] Pending,
   output logic [NUM_SRC-1:0] Mask
);

   localparam int unsigned IDX_W      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam logic [31:0] CAUSE_BASE = 32'h8000_0000;

   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } state_e;

   state_e             state_q, state_d;
   logic [NUM_SRC-1:0] irq_s;
   logic [NUM_SRC-1:0] irq_prev_q;
   logic [NUM_SRC-1:0] pend_q, pend_d;
   logic [NUM_SRC-1:0] mask_q, mask_d;
   logic [NUM_SRC-1:0] edge_det;
   logic [NUM_SRC-1:0] req;
   logic [NUM_SRC-1:0] cur_sel;
   logic [NUM_SRC-1:0] acc_clr;
   logic [IDX_W-1:0]   cur_q, cur_d;
   logic [IDX_W-1:0]   win_idx;
   logic               win_found;
   logic               int_q, int_d;
   logic [31:0]        cause_q, cause_d;

`ifdef INTC_IRQ_SYNC_EN
   logic [NUM_SRC-1:0] sync1_q, sync2_q;

   // Two-flop synchronizer per line; sources may be asynchronous to clk
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= IrqIn;
         sync2_q <= sync1_q;
      end
   end

   assign irq_s = sync2_q;
`else
   assign irq_s = IrqIn;
`endif

   // Edge detect, arbitration (lowest index wins) and one-hot decode of the in-flight source
   always_comb begin
      edge_det  = irq_s & ~irq_prev_q;
      req       = pend_q & mask_q;
      win_idx   = '0;
      win_found = 1'b0;
      cur_sel   = '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         if (req[i] && !win_found) begin
            win_idx   = IDX_W'(i);
            win_found = 1'b1;
         end
         cur_sel[i] = (cur_q == IDX_W'(i));
      end
   end

   // Request FSM: next state and registered request/cause values
   always_comb begin
      state_d = state_q;
      cur_d   = cur_q;
      int_d   = int_q;
      cause_d = cause_q;
      acc_clr = '0;
      case (state_q)
         IDLE: begin
            int_d = 1'b0;
            if (win_found) begin
               state_d = REQ;
               cur_d   = win_idx;
               cause_d = CAUSE_BASE | 32'(win_idx);
               int_d   = 1'b1;
            end
         end
         REQ: begin
            if (InteAccept) begin
               acc_clr = cur_sel;
               int_d   = 1'b0;
               state_d = IDLE;
            end else if (!(|(req & cur_sel))) begin
               int_d   = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            int_d   = 1'b0;
         end
      endcase
   end

   // A new edge outranks any clear hitting the same bit in the same cycle
   always_comb begin
      pend_d = (pend_q & ~({NUM_SRC{ClrWrite}} & ClrWdata) & ~acc_clr) | edge_det;
      mask_d = MaskWrite ? MaskWdata : mask_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         irq_prev_q <= '0;
         pend_q     <= '0;
         mask_q     <= '0;
         cur_q      <= '0;
         int_q      <= 1'b0;
         cause_q    <= '0;
      end else begin
         state_q    <= state_d;
         irq_prev_q <= irq_s;
         pend_q     <= pend_d;
         mask_q     <= mask_d;
         cur_q      <= cur_d;
         int_q      <= int_d;
         cause_q    <= cause_d;
      end
   end

   assign Interrupt = int_q;
   assign InteCause = cause_q;
   assign Pending   = pend_q;
   assign Mask      = mask_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// tb_interrupt_controller: directed vector table plus hand sequences for latency, refusal,
// non-preemption and reset during a request.
module tb_interrupt_controller;

   localparam int unsigned N = 8;
`ifdef INTC_IRQ_SYNC_EN
   localparam int unsigned EXTRA = 2;
`else
   localparam int unsigned EXTRA = 0;
`endif
   localparam int unsigned LAT = 2 + EXTRA;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [N-1:0] IrqIn = '0;
   logic         MaskWrite = 1'b0;
   logic [N-1:0] MaskWdata = '0;
   logic         ClrWrite = 1'b0;
   logic [N-1:0] ClrWdata = '0;
   logic         InteAccept = 1'b0;
   logic         Interrupt;
   logic [31:0]  InteCause;
   logic [N-1:0] Pending;
   logic [N-1:0] Mask;

   int errors = 0;
   int checks = 0;

   interrupt_controller #(.NUM_SRC(N)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .IrqIn      (IrqIn),
      .MaskWrite  (MaskWrite),
      .MaskWdata  (MaskWdata),
      .ClrWrite   (ClrWrite),
      .ClrWdata   (ClrWdata),
      .InteAccept (InteAccept),
      .Interrupt  (Interrupt),
      .InteCause  (InteCause),
      .Pending    (Pending),
      .Mask       (Mask)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [N-1:0] irq;
      logic         mw;
      logic [N-1:0] mwd;
      logic         cw;
      logic [N-1:0] cwd;
      logic         acc;
      logic         e_int;
      logic [31:0]  e_cause;
      logic [N-1:0] e_pend;
      logic [N-1:0] e_mask;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic [N-1:0] irq, input logic mw, input logic [N-1:0] mwd,
                      input logic cw, input logic [N-1:0] cwd, input logic acc,
                      input logic e_int, input logic [31:0] e_cause,
                      input logic [N-1:0] e_pend, input logic [N-1:0] e_mask);
      vec_t v;
      v.irq = irq; v.mw = mw; v.mwd = mwd; v.cw = cw; v.cwd = cwd; v.acc = acc;
      v.e_int = e_int; v.e_cause = e_cause; v.e_pend = e_pend; v.e_mask = e_mask;
      vecs.push_back(v);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic e_int, input logic [31:0] e_cause,
                          input logic [N-1:0] e_pend, input logic [N-1:0] e_mask);
      chk({tag, " Interrupt"}, 32'(Interrupt), 32'(e_int));
      chk({tag, " InteCause"}, InteCause, e_cause);
      chk({tag, " Pending"}, 32'(Pending), 32'(e_pend));
      chk({tag, " Mask"}, 32'(Mask), 32'(e_mask));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t         v;
      logic [N-1:0] prev_irq;
      int           n;

      // irq  mw mwd  cw cwd acc | int cause         pend  mask
      // basic request on source 2
      add(8'h00, 1, 8'h04, 0, 8'h00, 0, 0, 32'h0000_0000, 8'h00, 8'h04);
      add(8'h04, 0, 8'h00, 0, 8'h00, 0, 0, 32'h0000_0000, 8'h04, 8'h04);
      add(8'h00, 0, 8'h00, 0, 8'h00, 0, 1, 32'h8000_0002, 8'h04, 8'h04);
      add(8'h00, 0, 8'h00, 0, 8'h00, 1, 0, 32'h8000_0002, 8'h00, 8'h04);
      add(8'h00, 0, 8'h00, 0, 8'h00, 0, 0, 32'h8000_0002, 8'h00, 8'h04);
      // priority: sources 5 and 1 together
      add(8'h00, 1, 8'hFF, 0, 8'h00, 0, 0, 32'h8000_0002, 8'h00, 8'hFF);
      add(8'h22, 0, 8'h00, 0, 8'h00, 0, 0, 32'h8000_0002, 8'h22, 8'hFF);
      add(8'h22, 0, 8'h00, 0, 8'h00, 0, 1, 32'h8000_0001, 8'h22, 8'hFF);
      add(8'h22, 0, 8'h00, 0, 8'h00, 1, 0, 32'h8000_0001, 8'h20, 8'hFF);
      add(8'h22, 0, 8'h00, 0, 8'h00, 0, 1, 32'h8000_0005, 8'h20, 8'hFF);
      add(8'h22, 0, 8'h00, 0, 8'h00, 1, 0, 32'h8000_0005, 8'h00, 8'hFF);
      add(8'h00, 0, 8'h00, 0, 8'h00, 0, 0, 32'h8000_0005, 8'h00, 8'hFF);
      // withdraw source 3 via software clear
      add(8'h08, 0, 8'h00, 0, 8'h00, 0, 0, 32'h8000_0005, 8'h08, 8'hFF);
      add(8'h08, 0, 8'h00, 0, 8'h00, 0, 1, 32'h8000_0003, 8'h08, 8'hFF);
      add(8'h08, 0, 8'h00, 1, 8'h08, 0, 1, 32'h8000_0003, 8'h00, 8'hFF);
      add(8'h08, 0, 8'h00, 0, 8'h00, 0, 0, 32'h8000_0003, 8'h00, 8'hFF);
      add(8'h08, 0, 8'h00, 0, 8'h00, 0, 0, 32'h8000_0003, 8'h00, 8'hFF);
      add(8'h00, 0, 8'h00, 0, 8'h00, 0, 0, 32'h8000_0003, 8'h00, 8'hFF);
      // masking, then unmask
      add(8'h00, 1, 8'h00, 0, 8'h00, 0, 0, 32'h8000_0003, 8'h00, 8'h00);
      add(8'h01, 0, 8'h00, 0, 8'h00, 0, 0, 32'h8000_0003, 8'h01, 8'h00);
      add(8'h01, 0, 8'h00, 0, 8'h00, 0, 0, 32'h8000_0003, 8'h01, 8'h00);
      add(8'h01, 1, 8'h01, 0, 8'h00, 0, 0, 32'h8000_0003, 8'h01, 8'h01);
      add(8'h01, 0, 8'h00, 0, 8'h00, 0, 1, 32'h8000_0000, 8'h01, 8'h01);
      add(8'h01, 0, 8'h00, 0, 8'h00, 1, 0, 32'h8000_0000, 8'h00, 8'h01);
      add(8'h00, 0, 8'h00, 0, 8'h00, 0, 0, 32'h8000_0000, 8'h00, 8'h01);
      // set beats clear on source 4
      add(8'h00, 1, 8'h00, 0, 8'h00, 0, 0, 32'h8000_0000, 8'h00, 8'h00);
      add(8'h10, 0, 8'h00, 1, 8'h10, 0, 0, 32'h8000_0000, 8'h10, 8'h00);
      add(8'h10, 0, 8'h00, 1, 8'h10, 0, 0, 32'h8000_0000, 8'h00, 8'h00);
      add(8'h00, 0, 8'h00, 0, 8'h00, 0, 0, 32'h8000_0000, 8'h00, 8'h00);
      // new edge on the source being accepted keeps it pending
      add(8'h00, 1, 8'h04, 0, 8'h00, 0, 0, 32'h8000_0000, 8'h00, 8'h04);
      add(8'h04, 0, 8'h00, 0, 8'h00, 0, 0, 32'h8000_0000, 8'h04, 8'h04);
      add(8'h00, 0, 8'h00, 0, 8'h00, 0, 1, 32'h8000_0002, 8'h04, 8'h04);
      add(8'h04, 0, 8'h00, 0, 8'h00, 1, 0, 32'h8000_0002, 8'h04, 8'h04);
      add(8'h04, 0, 8'h00, 0, 8'h00, 0, 1, 32'h8000_0002, 8'h04, 8'h04);
      add(8'h04, 0, 8'h00, 0, 8'h00, 1, 0, 32'h8000_0002, 8'h00, 8'h04);
      add(8'h00, 0, 8'h00, 0, 8'h00, 0, 0, 32'h8000_0002, 8'h00, 8'h04);

      // reset state
      tick();
      chk_all("reset", 1'b0, 32'h0, 8'h00, 8'h00);
      rst_n = 1'b1;
      tick();
      chk_all("post_reset", 1'b0, 32'h0, 8'h00, 8'h00);

      // rising IrqIn changes get the synchronizer latency up front so each row's cycle lines up
      prev_irq = '0;
      for (int i = 0; i < vecs.size(); i++) begin
         v = vecs[i];
         if ((v.irq & ~prev_irq) != '0) begin
            IrqIn = v.irq;
            MaskWrite = 1'b0; ClrWrite = 1'b0; InteAccept = 1'b0;
            repeat (EXTRA) tick();
         end
         IrqIn      = v.irq;
         MaskWrite  = v.mw;
         MaskWdata  = v.mwd;
         ClrWrite   = v.cw;
         ClrWdata   = v.cwd;
         InteAccept = v.acc;
         tick();
         MaskWrite = 1'b0; ClrWrite = 1'b0; InteAccept = 1'b0;
         chk_all($sformatf("row%0d", i), v.e_int, v.e_cause, v.e_pend, v.e_mask);
         prev_irq = v.irq;
      end

      // end-to-end latency from first sampled edge to Interrupt
      MaskWrite = 1'b1; MaskWdata = 8'hFF;
      tick();
      MaskWrite = 1'b0;
      IrqIn = 8'h01;
      n = 0;
      while (Interrupt !== 1'b1 && n < 10) begin
         tick();
         n++;
      end
      chk("latency", 32'(n), 32'(LAT));
      chk("latency cause", InteCause, 32'h8000_0000);

      // refused request holds indefinitely; a higher index arrival must not disturb it
      IrqIn = 8'h09;
      for (int c = 0; c < 10; c++) begin
         tick();
         chk($sformatf("hold%0d Interrupt", c), 32'(Interrupt), 32'h1);
         chk($sformatf("hold%0d InteCause", c), InteCause, 32'h8000_0000);
      end
      chk("hold Pending", 32'(Pending), 32'h09);

      // asynchronous reset in REQ
      #2;
      rst_n = 1'b0;
      IrqIn = '0;
      #1;
      chk_all("mid_reset", 1'b0, 32'h0, 8'h00, 8'h00);
      repeat (3) tick();
      #4;
      rst_n = 1'b1;
      for (int c = 0; c < 8; c++) begin
         tick();
         chk($sformatf("after_reset%0d Interrupt", c), 32'(Interrupt), 32'h0);
      end
      chk("after_reset Pending", 32'(Pending), 32'h00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
